// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit type encoding and
// output-port indices used by the router input-port controller.
package noc_pkg;

    localparam int FLIT_W    = 64;
    localparam int COORD_W   = 4;
    localparam int NUM_PORTS = 5;

    // Output-port indices; a request vector is one-hot over these bits.
    localparam int PORT_N     = 0;
    localparam int PORT_S     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_t;

    function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_t'(flit[63:62]);
    endfunction

    function automatic logic [COORD_W-1:0] flit_dest_x(input logic [FLIT_W-1:0] flit);
        return flit[61:58];
    endfunction

    function automatic logic [COORD_W-1:0] flit_dest_y(input logic [FLIT_W-1:0] flit);
        return flit[57:54];
    endfunction

    // HEAD and HEADTAIL open a packet.
    function automatic logic is_head_type(input flit_type_t t);
        return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
    endfunction

    // TAIL and HEADTAIL close a packet.
    function automatic logic is_tail_type(input flit_type_t t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/input_port_ctrl_if.sv
// Bundle of the input-port controller's buffer, allocator and crossbar
// signals. The slave modport is the controller's view; master is the
// environment's view. Optional err_cnt_o exists when INPORT_ERR_CNT_EN
// is defined.
//
// Handshake: the buffer presents a flit whenever buf_empty_i is low
// (first-word fall-through); it is consumed at a rising edge where
// buf_read_o is high. Toward the crossbar a flit transfers at a rising
// edge where flit_valid_o and out_ready_i are both high; the controller
// pops the buffer on exactly those edges while a packet is active.
interface input_port_ctrl_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0]    buf_flit_i;
    logic                 buf_empty_i;
    logic                 buf_read_o;
    logic [NUM_PORTS-1:0] req_o;
    logic                 grant_i;
    logic                 out_ready_i;
    logic [FLIT_W-1:0]    flit_o;
    logic                 flit_valid_o;
    logic                 err_o;
`ifdef INPORT_ERR_CNT_EN
    logic [15:0]          err_cnt_o;
`endif

    modport slave (
        input  buf_flit_i, buf_empty_i, grant_i, out_ready_i,
        output buf_read_o, req_o, flit_o, flit_valid_o, err_o
`ifdef INPORT_ERR_CNT_EN
        , output err_cnt_o
`endif
    );

    modport master (
        output buf_flit_i, buf_empty_i, grant_i, out_ready_i,
        input  buf_read_o, req_o, flit_o, flit_valid_o, err_o
`ifdef INPORT_ERR_CNT_EN
        , input err_cnt_o
`endif
    );

endinterface

// File: rtl/input_port_ctrl_xy_route_calc.sv
// Dimension-ordered (X first, then Y) route decision for one flit.
// Purely combinational; produces a one-hot output-port vector.
module xy_route_calc
    import noc_pkg::*;
(
    input  logic [COORD_W-1:0]   dest_x,
    input  logic [COORD_W-1:0]   dest_y,
    input  logic [COORD_W-1:0]   cur_x,
    input  logic [COORD_W-1:0]   cur_y,
    output logic [NUM_PORTS-1:0] port_oh
);

    // Resolve X first; Y is only considered once X matches.
    always_comb begin
        port_oh = '0;
        if (dest_x > cur_x) begin
            port_oh[PORT_E] = 1'b1;
        end else if (dest_x < cur_x) begin
            port_oh[PORT_W] = 1'b1;
        end else if (dest_y > cur_y) begin
            port_oh[PORT_N] = 1'b1;
        end else if (dest_y < cur_y) begin
            port_oh[PORT_S] = 1'b1;
        end else begin
            port_oh[PORT_LOCAL] = 1'b1;
        end
    end

endmodule

// File: rtl/input_port_ctrl.sv
// Router input-port controller: routes a packet's head flit, requests
// an output port from the switch allocator and, once granted, streams
// the packet (wormhole) from the input buffer to the crossbar.
// Flits arriving outside a packet are dropped with an err_o pulse.
// Optional feature: INPORT_ERR_CNT_EN adds a saturating drop counter
// err_cnt_o.
module input_port_ctrl
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_COORD = 4'd0,
    parameter logic [COORD_W-1:0] Y_COORD = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    input_port_ctrl_if.slave   port_if,
    output logic [1:0]         state_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROUTE  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [NUM_PORTS-1:0] route_q;
    logic [NUM_PORTS-1:0] route_calc;
    flit_type_t           head_type;
    logic                 head_ok;

    logic                 read_c;
    logic                 valid_c;
    logic                 err_c;
    logic [NUM_PORTS-1:0] req_c;
    logic [FLIT_W-1:0]    flit_c;

    assign head_type = flit_type(port_if.buf_flit_i);
    assign head_ok   = !port_if.buf_empty_i;

    xy_route_calc u_route_calc (
        .dest_x  (flit_dest_x(port_if.buf_flit_i)),
        .dest_y  (flit_dest_y(port_if.buf_flit_i)),
        .cur_x   (X_COORD),
        .cur_y   (Y_COORD),
        .port_oh (route_calc)
    );

    // Next state and outputs; all outputs forced low while reset is held.
    always_comb begin
        state_d = state_q;
        read_c  = 1'b0;
        valid_c = 1'b0;
        err_c   = 1'b0;
        req_c   = '0;
        flit_c  = '0;
        case (state_q)
            IDLE: begin
                if (head_ok) begin
                    if (is_head_type(head_type)) begin
                        state_d = ROUTE;
                    end else begin
                        read_c = 1'b1;
                        err_c  = 1'b1;
                    end
                end
            end
            ROUTE: begin
                req_c = route_q;
                if (port_if.grant_i) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                req_c   = route_q;
                flit_c  = port_if.buf_flit_i;
                valid_c = head_ok;
                read_c  = head_ok && port_if.out_ready_i;
                if (read_c && is_tail_type(head_type)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            state_d = IDLE;
            read_c  = 1'b0;
            valid_c = 1'b0;
            err_c   = 1'b0;
            req_c   = '0;
            flit_c  = '0;
        end
    end

    // State register and route latch captured when a head is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && head_ok && is_head_type(head_type)) begin
                route_q <= route_calc;
            end
        end
    end

    assign port_if.buf_read_o   = read_c;
    assign port_if.flit_valid_o = valid_c;
    assign port_if.err_o        = err_c;
    assign port_if.req_o        = req_c;
    assign port_if.flit_o       = flit_c;
    assign state_o              = state_q;

`ifdef INPORT_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Count drops, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (err_c && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign port_if.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter X_COORD, default 0, this router's 4-bit X position.
REQ-002 SHALL have parameter Y_COORD, default 0, this router's 4-bit Y position.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port buf_flit_i  input  64  head flit of the upstream input buffer (first-word fall-through).
REQ-006 SHALL have port buf_empty_i  input  1  upstream buffer is empty; buf_flit_i is invalid.
REQ-007 SHALL have port buf_read_o  output  1  pops the buffer head at this clock edge.
REQ-008 SHALL have port req_o  output  5  one-hot output-port request {LOCAL,W,E,S,N} = bits [4:0].
REQ-009 SHALL have port grant_i  input  1  switch allocator grants req_o for this input.
REQ-010 SHALL have port out_ready_i  input  1  crossbar/downstream accepts a flit this cycle.
REQ-011 SHALL have port flit_o  output  64  flit toward the crossbar.
REQ-012 SHALL have port flit_valid_o  output  1  flit_o is valid.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse when an out-of-packet flit is dropped.

Function
REQ-014 SHALL decode flit type from bits [63:62]: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL; dest X = [61:58], dest Y = [57:54].
REQ-015 SHALL route XY: dx>X_COORD -> E; dx<X_COORD -> W; else dy>Y_COORD -> N; dy<Y_COORD -> S; else LOCAL; 4-bit unsigned compares.
REQ-016 SHALL implement FSM states IDLE, ROUTE, ACTIVE.
REQ-017 IDLE: when !buf_empty_i and type is HEAD/HEADTAIL, SHALL register the route in route_q and enter ROUTE next cycle without popping.
REQ-018 IDLE: when !buf_empty_i and type is BODY/TAIL, SHALL assert buf_read_o and err_o that cycle (drop) and stay in IDLE.
REQ-019 ROUTE: req_o SHALL equal route_q; on grant_i SHALL enter ACTIVE next cycle; without grant, SHALL hold indefinitely.
REQ-020 ACTIVE: req_o SHALL stay route_q (wormhole lock); flit_o = buf_flit_i; flit_valid_o = !buf_empty_i; buf_read_o = !buf_empty_i && out_ready_i.
REQ-021 ACTIVE: a popped TAIL/HEADTAIL SHALL return the FSM to IDLE next cycle; req_o SHALL be 0 from that cycle.
REQ-022 ACTIVE: an empty buffer mid-packet SHALL stall (valid low, no pop) without leaving ACTIVE.
REQ-023 ACTIVE: a HEAD flit SHALL be forwarded as a body flit; no re-route occurs.
REQ-024 Latency: head visible at edge t -> req_o at t+1; grant at t' -> head forwarded at t'+1 at the earliest; throughput 1 flit/cycle.
REQ-025 In IDLE and ROUTE, flit_valid_o SHALL be 0; buf_read_o SHALL be 0 except under REQ-018.

Reset
REQ-026 With reset low at a clock edge, FSM SHALL enter IDLE and route_q SHALL clear to 0.
REQ-027 During and after reset, outputs SHALL be 0 (buf_read_o, req_o, flit_valid_o, err_o) and flit_o SHALL be 0.
REQ-028 Reset mid-packet SHALL abandon the packet; the remaining flits are then dropped per REQ-018.

Configuration
REQ-029 With INPORT_ERR_CNT_EN defined, SHALL add output err_cnt_o[15:0], counting err_o pulses, saturating at 16'hFFFF, cleared by reset.
REQ-030 Without INPORT_ERR_CNT_EN, SHALL omit err_cnt_o and the counter; all other behaviour is unchanged.

Structure
REQ-031 Package noc_pkg SHALL hold the flit_type_t enum, the port index constants (N=0, S=1, E=2, W=3, LOCAL=4), FLIT_W=64 and COORD_W=4.
REQ-032 The combinational XY decision SHALL be sub-module xy_route_calc (inputs: dest, current coordinates; output: one-hot port).

Verification
REQ-033 X=Y=1; HEAD dest(3,1), BODY, TAIL; grant 2 cycles later; ready high -> req_o=00100 (E), 3 flits forwarded in consecutive cycles, FSM back in IDLE, req_o=0.
REQ-034 X=Y=1; HEADTAIL dest(1,1) -> req_o=10000 (LOCAL); after grant, one flit forwarded, then IDLE.
REQ-035 BODY flit at buffer head in IDLE -> one pop, err_o pulse; with macro, err_cnt_o=1.
REQ-036 ACTIVE, out_ready_i low 3 cycles with buffer non-empty -> no pop, flit_valid_o high, flit_o stable.
REQ-037 reset low mid-packet after 2 of 4 flits -> next cycle IDLE, outputs 0; the next 2 flits are dropped with 2 err_o pulses.
REQ-038 Saturation (macro on): force 65536 drops -> err_cnt_o stays 16'hFFFF.
